// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg: opcodes, controller states and datapath mux encodings  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef logic [3:0] state_t;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  // Shared with the ALU-control decoder.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_ct_op_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_RS     = 2'b11
  } pc_source_e;

endpackage
`default_nettype wire

// File: rtl/mc_main_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_main_ctrl_if: controller <-> datapath/memory signal bundle    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ct_op;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ct_op,
           pc_source, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ct_op,
           pc_source, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_next_state.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_next_state: combinational next-state logic of the controller  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mc_next_state
  import mips_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output logic [3:0] o_next_state
);

  always_comb begin
    o_next_state = S_TRAP;
    case (i_state)
      S_FETCH:  o_next_state = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE: begin
            if (i_funct == FN_ADDU)     o_next_state = S_EXEC;
            else if (i_funct == FN_JR)  o_next_state = S_JR;
            else                        o_next_state = S_TRAP;
          end
          OP_LW, OP_SW: o_next_state = S_MEMADR;
          OP_BEQ:       o_next_state = S_BRANCH;
          OP_J:         o_next_state = S_JUMP;
          OP_ADDIU:     o_next_state = S_ADDIEX;
          default:      o_next_state = S_TRAP;
        endcase
      end
      // Opcode is held in IR, so it still selects load vs store here.
      S_MEMADR: begin
        if (i_opcode == OP_LW)      o_next_state = S_MEMRD;
        else if (i_opcode == OP_SW) o_next_state = S_MEMWR;
        else                        o_next_state = S_TRAP;
      end
      S_MEMRD:  o_next_state = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  o_next_state = S_FETCH;
      S_MEMWR:  o_next_state = i_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   o_next_state = S_ALUWB;
      S_ALUWB:  o_next_state = S_FETCH;
      S_BRANCH: o_next_state = S_FETCH;
      S_JUMP:   o_next_state = S_FETCH;
      S_ADDIEX: o_next_state = S_ADDIWB;
      S_ADDIWB: o_next_state = S_FETCH;
      S_JR:     o_next_state = S_FETCH;
      default:  o_next_state = S_TRAP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_main_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_main_ctrl: multicycle MIPS main controller FSM                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mc_main_ctrl
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mc_main_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_i_or_d;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_alu_ct_op, w_pc_source;

  mc_next_state u_next_state (
    .i_state      (r_state),
    .i_opcode     (bus.opcode),
    .i_funct      (bus.funct),
    .i_mem_ready  (bus.mem_ready),
    .o_next_state (w_next_state)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_alu_ct_op  = ALU_ADD;
    w_pc_source  = PCS_ALU;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      S_DECODE: w_alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_ct_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_ct_op = ALU_SUB;
        w_pc_source = PCS_ALUOUT;
        w_pc_write  = bus.zero;
      end
      S_JUMP: begin
        w_pc_source = PCS_JUMP;
        w_pc_write  = 1'b1;
      end
      S_JR: begin
        w_pc_source = PCS_RS;
        w_pc_write  = 1'b1;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every output, including the debug state.
  assign bus.pc_write   = w_pc_write   & rst;
  assign bus.ir_write   = w_ir_write   & rst;
  assign bus.mem_read   = w_mem_read   & rst;
  assign bus.mem_write  = w_mem_write  & rst;
  assign bus.i_or_d     = w_i_or_d     & rst;
  assign bus.reg_write  = w_reg_write  & rst;
  assign bus.reg_dst    = w_reg_dst    & rst;
  assign bus.mem_to_reg = w_mem_to_reg & rst;
  assign bus.alu_src_a  = w_alu_src_a  & rst;
  assign bus.alu_src_b  = w_alu_src_b  & {2{rst}};
  assign bus.alu_ct_op  = w_alu_ct_op  & {2{rst}};
  assign bus.pc_source  = w_pc_source  & {2{rst}};
  assign bus.illegal    = w_illegal    & rst;
  assign bus.state      = r_state      & {4{rst}};

endmodule
`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mc_main_ctrl: directed + random instruction streams vs model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mc_main_ctrl;

  localparam int K_ADDU = 0, K_JR = 1, K_ADDIU = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_J = 6, K_BADOP = 7, K_BADFN = 8;

  typedef struct {
    int st;
    bit mr;
    bit z;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  step_t q[$];

  always #5 clk = ~clk;

  mc_main_ctrl_if bus();

  mc_main_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic bit rbit();
    return bit'($urandom & 32'd1);
  endfunction

  function automatic logic [15:0] get_out();
    return {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.i_or_d,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_ct_op, bus.pc_source, bus.illegal};
  endfunction

  // Expected control word for each numbered controller step.
  function automatic logic [15:0] exp_out(input int st, input bit mr, input bit z);
    logic pw = 0, iw = 0, rd = 0, wr = 0, iod = 0, rw = 0, dst = 0, m2r = 0, sa = 0, il = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (st)
      0:      begin rd = 1; sb = 2'b01; iw = mr; pw = mr; end
      1:      sb = 2'b11;
      2, 10:  begin sa = 1; sb = 2'b10; end
      3:      begin rd = 1; iod = 1; end
      4:      begin rw = 1; m2r = 1; end
      5:      begin wr = 1; iod = 1; end
      6:      begin sa = 1; op = 2'b10; end
      7:      begin rw = 1; dst = 1; end
      8:      begin sa = 1; op = 2'b01; ps = 2'b01; pw = z; end
      9:      begin ps = 2'b10; pw = 1; end
      11:     rw = 1;
      12:     begin ps = 2'b11; pw = 1; end
      13:     il = 1;
      default: ;
    endcase
    return {pw, iw, rd, wr, iod, rw, dst, m2r, sa, sb, op, ps, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push1(input int st);
    q.push_back('{st: st, mr: rbit(), z: rbit()});
  endfunction

  function automatic void push_mem(input int st, input int stalls);
    for (int i = 0; i < stalls; i++) q.push_back('{st: st, mr: 1'b0, z: rbit()});
    q.push_back('{st: st, mr: 1'b1, z: rbit()});
  endfunction

  task automatic run_q(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.mem_ready = s.mr;
      bus.zero      = s.z;
      @(negedge clk);
      chk({tag, " state"}, 32'(bus.state), 32'(s.st));
      chk({tag, " outs"}, 32'(get_out()), 32'(exp_out(s.st, s.mr, s.z)));
      chk({tag, " rd&wr"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
      chk({tag, " rw&pw"}, 32'(bus.reg_write & bus.pc_write), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rbit();
      bus.zero      = rbit();
      @(negedge clk);
      chk("reset state", 32'(bus.state), 32'd0);
      chk("reset outs", 32'(get_out()), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  task automatic pick(input int kind, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    op = 6'b000000;
    case (kind)
      K_ADDU:  fn = 6'b100001;
      K_JR:    fn = 6'b001000;
      K_ADDIU: op = 6'b001001;
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_BEQ:   op = 6'b000100;
      K_J:     op = 6'b000010;
      K_BADOP: do op = 6'($urandom);
               while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001001});
      default: do fn = 6'($urandom); while (fn inside {6'b100001, 6'b001000});
    endcase
  endtask

  // Builds the expected step trace of one instruction, runs it, and resets
  // afterwards if the instruction trapped or was cut short.
  task automatic run_instr(input string tag, input int kind, input logic [5:0] op,
                           input logic [5:0] fn, input int fst, input int mst,
                           input bit zf, input int cut);
    bus.opcode = op;
    bus.funct  = fn;
    q.delete();
    push_mem(0, fst);
    push1(1);
    case (kind)
      K_ADDU:  begin push1(6); push1(7); end
      K_JR:    push1(12);
      K_ADDIU: begin push1(10); push1(11); end
      K_LW:    begin push1(2); push_mem(3, mst); push1(4); end
      K_SW:    begin push1(2); push_mem(5, mst); end
      K_BEQ:   q.push_back('{st: 8, mr: rbit(), z: zf});
      K_J:     push1(9);
      default: repeat (10) push1(13);
    endcase
    if (cut > 0) while (q.size() > cut) void'(q.pop_back());
    run_q(tag);
    if (cut > 0 || kind >= K_BADOP) do_reset($urandom_range(2, 3));
  endtask

  initial begin
    logic [5:0] op, fn;
    int kind, fst, mst, cut;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr("addu", K_ADDU, 6'b000000, 6'b100001, 0, 0, 1'b0, 0);
    run_instr("lw stall", K_LW, 6'b100011, 6'b010101, 0, 2, 1'b0, 0);
    run_instr("beq z1", K_BEQ, 6'b000100, 6'b000000, 0, 0, 1'b1, 0);
    run_instr("beq z0", K_BEQ, 6'b000100, 6'b000000, 0, 0, 1'b0, 0);
    run_instr("bad op", K_BADOP, 6'b111111, 6'b100001, 0, 0, 1'b0, 0);
    run_instr("bad fn", K_BADFN, 6'b000000, 6'b000000, 0, 0, 1'b0, 0);
    run_instr("sw abort", K_SW, 6'b101011, 6'b000000, 0, 2, 1'b0, 5);
    run_instr("jr", K_JR, 6'b000000, 6'b001000, 1, 0, 1'b0, 0);
    run_instr("j", K_J, 6'b000010, 6'b000000, 0, 0, 1'b0, 0);
    run_instr("addiu", K_ADDIU, 6'b001001, 6'b000000, 0, 0, 1'b0, 0);
    run_instr("sw", K_SW, 6'b101011, 6'b000000, 0, 0, 1'b0, 0);

    for (int n = 0; n < 80; n++) begin
      kind = ($urandom_range(0, 15) == 0) ? $urandom_range(K_BADOP, K_BADFN)
                                          : $urandom_range(K_ADDU, K_J);
      pick(kind, op, fn);
      fst = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      mst = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0;
      run_instr("rand", kind, op, fn, fst, mst, rbit(), cut);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle MIPS main controller: the FSM that drives alu_ct_op into the ALU-control decoder, plus all datapath enables and muxes.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.
- Waits on a memory ready handshake.
- Supported instructions: addu, jr, addiu, lw, sw, beq, j. Any other encoding traps.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch-equal
- OP_J, 6'b000010, jump
- OP_ADDIU, 6'b001001, add immediate unsigned

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address select: 0=PC, 1=ALUOut
- reg_write  out  1  register file write
- reg_dst  out  1  destination register: 0=rt, 1=rd
- mem_to_reg  out  1  write-back data: 0=ALUOut, 1=MDR
- alu_src_a  out  1  ALU A operand: 0=PC, 1=A register
- alu_src_b  out  2  ALU B operand: 00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
- alu_ct_op  out  2  00=add, 01=sub, 10=use funct
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target, 11=rs
- illegal  out  1  sticky trap flag
- state  out  4  current state, for debug

Behaviour:
- Reset: rst, synchronous, active-low.
  - While rst=0, all outputs are forced to 0.
  - The state register loads FETCH on the next edge.
  - Reset in any state, including mid-memory-wait or TRAP, aborts the operation; the first cycle after release is FETCH.
- Output timing:
  - Outputs are combinational from the state register.
  - Only exceptions: pc_write in BRANCH is gated by zero; pc_write/ir_write in FETCH are gated by mem_ready.
  - Any unlisted output is 0.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, JR=12, TRAP=13.
  - Encodings 14/15 go to TRAP.
- FETCH: mem_read=1, i_or_d=0, alu_src_b=01, alu_ct_op=00, pc_source=00; ir_write=pc_write=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ct_op=00 (precomputes the branch target). Next state by opcode:
  - R-type with funct 100001 -> EXEC
  - R-type with funct 001000 -> JR
  - R-type with any other funct -> TRAP
  - LW or SW -> MEMADR
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDIU -> ADDIEX
  - any other opcode -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ct_op=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_source=01, pc_write=zero. Next: FETCH.
- JUMP: pc_source=10, pc_write=1. Next: FETCH.
- JR: pc_source=11, pc_write=1. Next: FETCH.
- TRAP: illegal=1, all other outputs 0. Absorbing state; leave only by reset.
- Latencies with mem_ready tied high, in cycles:
  - addu / addiu / lw: 4 / 4 / 5
  - sw / beq / j / jr: 4 / 3 / 3 / 3
  - Each mem_ready=0 cycle adds one cycle.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and pc_write are never both 1.

Decomposition:
- Shared package mips_pkg holds:
  - the opcode and funct constants
  - the state enum
  - the alu_ct_op encodings (ADD=00, SUB=01, FUNCT=10), also used by the ALU-control decoder
  - the alu_src_b and pc_source encodings
- Optional sub-module mc_next_state: purely combinational next-state logic from (state, opcode, funct, mem_ready).
- Output decode stays in the top-level module.

Test Plan:
- Reset hold: rst=0 for 3 cycles in any state -> all outputs 0; first cycle after release shows state=0, mem_read=1.
- addu (opcode 0, funct 100001), mem_ready=1 -> states 0,1,6,7; alu_ct_op=10 in EXEC; reg_write=1 with reg_dst=1 in cycle 4.
- lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; mem_to_reg=1 in MEMWB; 7 cycles total.
- beq twice, once with zero=1 and once with zero=0 -> alu_ct_op=01 and pc_source=01 in BRANCH; pc_write equals zero.
- Illegal opcode 6'b111111, then R-type with funct 6'b000000 -> TRAP with illegal=1 held for 10 cycles; rst=0 clears it.
- Reset mid-MEMWR with mem_ready=0 -> mem_write drops during reset; restart at FETCH with no write issued.
